// File: rtl/sc_fifo_pkg.sv
// Shared definitions for the single-clock FIFO and its width down-converter:
// state encodings, a constant clog2 and the RATIO/IDW legality check.
`ifndef SC_FIFO_PKG_SV
`define SC_FIFO_PKG_SV

// True when RATIO is a power of two of at least 2 and divides IDW evenly.
`define SC_FIFO_DNCONV_LEGAL(iw, r) \
  (((r) >= 32'sd2) && ((((r) & ((r) - 32'sd1))) == 32'sd0) && (((iw) % (r)) == 32'sd0))

package sc_fifo_pkg;

  // Converter state: IDLE holds nothing, SHIFT holds a word being sliced.
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Ceiling log2 for elaboration-time width derivation.
  function automatic int sc_clog2(input int value);
    int res;
    int v;
    res = 32'sd0;
    v   = value - 32'sd1;
    while (v > 32'sd0) begin
      res = res + 32'sd1;
      v   = v >>> 32'sd1;
    end
    return res;
  endfunction

endpackage

`endif

// File: rtl/sc_fifo_width_dnconv.sv
// Width down-converter behind a show-ahead single-clock FIFO. Each IDW-bit
// head word is popped once and emitted as RATIO narrow slices, LSB slice
// first, on a valid/ready stream. A new word is popped in the same cycle the
// last slice of the previous one transfers, so slices flow without bubbles.
module sc_fifo_width_dnconv
  import sc_fifo_pkg::*;
#(
  parameter int IDW   = 32,
  parameter int RATIO = 4,
  parameter int CNTW  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [IDW-1:0]         fifo_dataout,
  input  logic                   fifo_empty,
  output logic                   fifo_rd_op,
  output logic [(IDW/RATIO)-1:0] out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  input  logic                   flush,
  output logic                   busy,
  output logic [CNTW-1:0]        word_cnt
);

  localparam int ODW  = IDW / RATIO;
  localparam int IDXW = sc_clog2(RATIO);

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(RATIO - 32'sd1);
  localparam logic [IDXW-1:0] IDX_ZERO = IDXW'(32'd0);
  localparam logic [IDXW-1:0] IDX_ONE  = IDXW'(32'd1);
  localparam logic [CNTW-1:0] CNT_ZERO = CNTW'(32'd0);
  localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(32'd1);
  localparam logic [CNTW-1:0] CNT_MAX  = {CNTW{1'b1}};

  // Refuse to elaborate with a ratio that cannot slice the word evenly.
  generate
    if (!`SC_FIFO_DNCONV_LEGAL(IDW, RATIO)) begin : g_illegal_params
      $error("sc_fifo_width_dnconv: RATIO must be a power of two >= 2 dividing IDW");
    end
  endgenerate

  state_t            state_r;
  logic [IDXW-1:0]   idx_r;
  logic [IDW-1:0]    hold_data_r;
  logic [CNTW-1:0]   word_cnt_r;

  logic              valid_s;
  logic              last_s;
  logic              xfer_s;
  logic              load_s;

  // Stream decode straight from the state registers.
  assign valid_s = (state_r == SHIFT);
  assign last_s  = valid_s & (idx_r == LAST_IDX);
  assign xfer_s  = valid_s & out_ready;

  // Pop only when the FIFO has data and the holding register is (or is about
  // to become) free; reset and flush both suppress the pop.
  assign load_s  = ~reset & ~flush & ~fifo_empty & (~valid_s | (xfer_s & last_s));

  assign fifo_rd_op = load_s;
  assign out_valid  = valid_s;
  assign busy       = valid_s;
  assign out_last   = last_s;
  assign out_data   = hold_data_r[idx_r * ODW +: ODW];
  assign word_cnt   = word_cnt_r;

  // Holding register, slice index, state and saturating word counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      idx_r       <= IDX_ZERO;
      hold_data_r <= {IDW{1'b0}};
      word_cnt_r  <= CNT_ZERO;
    end else if (flush) begin
      // Drop the held word; a coincident last-slice transfer is not counted.
      state_r <= IDLE;
      idx_r   <= IDX_ZERO;
    end else begin
      if (load_s) begin
        hold_data_r <= fifo_dataout;
        idx_r       <= IDX_ZERO;
        state_r     <= SHIFT;
      end else if (xfer_s && !last_s) begin
        idx_r <= idx_r + IDX_ONE;
      end else if (xfer_s && last_s) begin
        state_r <= IDLE;
      end

      if (xfer_s && last_s && (word_cnt_r != CNT_MAX)) begin
        word_cnt_r <= word_cnt_r + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_sc_fifo_width_dnconv.sv
// Self-checking bench for sc_fifo_width_dnconv. The bench plays the FIFO
// (a queue of words) and keeps an abstract model: the list of slices still
// owed for the held word plus a saturating count of completed words.
module tb_sc_fifo_width_dnconv;

  localparam int IDW   = 32;
  localparam int RATIO = 4;
  localparam int CNTW  = 4;
  localparam int ODW   = IDW / RATIO;
  localparam int CMAX  = (1 << CNTW) - 1;

  logic            clk = 1'b0;
  logic            reset;
  logic            flush;
  logic            out_ready;
  logic            fifo_empty;
  logic [IDW-1:0]  fifo_dataout;
  logic            fifo_rd_op;
  logic [ODW-1:0]  out_data;
  logic            out_valid;
  logic            out_last;
  logic            busy;
  logic [CNTW-1:0] word_cnt;

  logic [IDW-1:0] fifo_q[$];
  logic [ODW-1:0] held_q[$];
  logic [ODW-1:0] obs_q[$];
  int             obs_cyc_q[$];
  int             exp_cnt;
  int             dut_pops;
  int             cyc;
  int             errors = 0;
  int             checks = 0;

  always #5 clk = ~clk;

  sc_fifo_width_dnconv #(
    .IDW  (IDW),
    .RATIO(RATIO),
    .CNTW (CNTW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .fifo_dataout(fifo_dataout),
    .fifo_empty  (fifo_empty),
    .fifo_rd_op  (fifo_rd_op),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last),
    .flush       (flush),
    .busy        (busy),
    .word_cnt    (word_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_fifo();
    fifo_empty   = (fifo_q.size() == 0);
    fifo_dataout = (fifo_q.size() == 0) ? '0 : fifo_q[0];
  endtask

  // One clock cycle: called just after a falling edge with inputs already set.
  task automatic step();
    bit             e_valid, e_last, e_xfer, e_pop;
    logic [IDW-1:0] w;
    drive_fifo();
    #1;
    e_valid = (held_q.size() != 0);
    e_last  = (held_q.size() == 1);
    e_xfer  = e_valid && out_ready;
    e_pop   = !reset && !flush && (fifo_q.size() != 0) && (!e_valid || (e_xfer && e_last));
    chk("out_valid", out_valid, e_valid);
    chk("busy", busy, e_valid);
    chk("out_last", out_last, e_valid && e_last);
    chk("fifo_rd_op", fifo_rd_op, e_pop);
    chk("word_cnt", word_cnt, exp_cnt);
    if (e_valid) chk("out_data", out_data, held_q[0]);
    if (out_valid && out_ready) begin
      obs_q.push_back(out_data);
      obs_cyc_q.push_back(cyc);
    end
    if (fifo_rd_op) dut_pops++;
    @(posedge clk);
    cyc++;
    if (reset) begin
      held_q.delete();
      exp_cnt = 0;
    end else if (flush) begin
      held_q.delete();
    end else begin
      if (e_xfer) begin
        void'(held_q.pop_front());
        if (e_last && exp_cnt < CMAX) exp_cnt++;
      end
      if (e_pop) begin
        w = fifo_q.pop_front();
        for (int i = 0; i < RATIO; i++) held_q.push_back(w[i*ODW +: ODW]);
      end
    end
    @(negedge clk);
  endtask

  task automatic clear_obs();
    obs_q.delete();
    obs_cyc_q.delete();
    dut_pops = 0;
  endtask

  task automatic do_reset();
    fifo_q.delete();
    reset = 1'b1;
    flush = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    reset = 1'b0;
    clear_obs();
  endtask

  task automatic chk_stream(input string tag, input logic [ODW-1:0] exp[$]);
    chk({tag, "_len"}, obs_q.size(), exp.size());
    for (int i = 0; i < exp.size(); i++) begin
      if (i < obs_q.size()) chk({tag, "_slice"}, obs_q[i], exp[i]);
      else chk({tag, "_missing"}, 64'd0, 64'd1);
    end
  endtask

  initial begin
    logic [ODW-1:0] e[$];
    reset = 1'b1;
    flush = 1'b0;
    out_ready = 1'b1;
    exp_cnt = 0;
    dut_pops = 0;
    cyc = 0;
    drive_fifo();
    @(negedge clk);

    // Reset state
    do_reset();
    chk("rst_data", out_data, 0);
    chk("rst_cnt", word_cnt, 0);

    // Single word
    fifo_q.push_back(32'hDDCCBBAA);
    for (int i = 0; i < 6; i++) step();
    e = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    chk_stream("single", e);
    chk("single_pops", dut_pops, 1);
    chk("single_cnt", word_cnt, 1);
    chk("single_idle", out_valid, 0);

    // Back-to-back words, no bubble
    do_reset();
    fifo_q.push_back(32'h03020100);
    fifo_q.push_back(32'h07060504);
    for (int i = 0; i < 10; i++) step();
    e = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
    chk_stream("b2b", e);
    if (obs_cyc_q.size() == 8) chk("b2b_nobubble", obs_cyc_q[7] - obs_cyc_q[0], 7);
    else chk("b2b_xfers", obs_cyc_q.size(), 8);
    chk("b2b_pops", dut_pops, 2);
    chk("b2b_cnt", word_cnt, 2);

    // Backpressure
    do_reset();
    fifo_q.push_back(32'h44332211);
    for (int i = 0; i < 14; i++) begin
      out_ready = (i % 3 == 0);
      step();
    end
    out_ready = 1'b1;
    e = '{8'h11, 8'h22, 8'h33, 8'h44};
    chk_stream("bp", e);
    chk("bp_pops", dut_pops, 1);
    chk("bp_cnt", word_cnt, 1);

    // Empty guard
    do_reset();
    for (int i = 0; i < 20; i++) step();
    chk("empty_pops", dut_pops, 0);
    chk("empty_valid", out_valid, 0);
    chk("empty_cnt", word_cnt, 0);

    // Flush after the first slice
    do_reset();
    fifo_q.push_back(32'h44332211);
    fifo_q.push_back(32'h88776655);
    step();
    step();
    chk("flush_first", (obs_q.size() == 1) ? obs_q[0] : 8'h00, 8'h11);
    flush = 1'b1;
    clear_obs();
    step();
    chk("flush_nopop", dut_pops, 0);
    flush = 1'b0;
    clear_obs();
    for (int i = 0; i < 6; i++) step();
    e = '{8'h55, 8'h66, 8'h77, 8'h88};
    chk_stream("flush", e);
    chk("flush_pops", dut_pops, 1);
    chk("flush_cnt", word_cnt, 1);

    // Reset in the middle of a word
    do_reset();
    fifo_q.push_back(32'hCAFEF00D);
    fifo_q.push_back(32'h12345678);
    for (int i = 0; i < 3; i++) step();
    chk("midrst_slice2", out_data, 8'hFE);
    reset = 1'b1;
    clear_obs();
    for (int i = 0; i < 3; i++) step();
    chk("midrst_pops", dut_pops, 0);
    chk("midrst_valid", out_valid, 0);
    chk("midrst_data", out_data, 0);
    chk("midrst_cnt", word_cnt, 0);
    reset = 1'b0;

    // Counter saturation
    do_reset();
    for (int i = 0; i < 100; i++) begin
      if (fifo_q.size() < 3) fifo_q.push_back($urandom());
      step();
    end
    chk("sat_cnt", word_cnt, CMAX);

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 800; i++) begin
      if (fifo_q.size() < 6 && $urandom_range(0, 2) != 0) fifo_q.push_back($urandom());
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      reset     = ($urandom_range(0, 299) == 0);
      step();
    end
    reset = 1'b0;
    flush = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sc_fifo_width_dnconv.md
Name: sc_fifo_width_dnconv

Overview:
Downstream consumer of the single-clock FIFO.
- Pops IDW-bit words from the FIFO's show-ahead read port (read data is valid in the same cycle while empty=0).
- Serialises each word into RATIO narrower slices, LSB slice first.
- Presents the slices on a valid/ready stream toward the narrow egress datapath.
- Never pops an empty FIFO, so the FIFO's rd_empty_err never fires through this block.

Parameters:
- IDW, 32: FIFO word width. Must be divisible by RATIO.
- RATIO, 4: slices per word. Power of two, at least 2.
- CNTW, 16: width of the consumed-word counter.
- Derived locals: ODW = IDW/RATIO; IDXW = clog2(RATIO).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- fifo_dataout  in  IDW  FIFO head word (show-ahead).
- fifo_empty  in  1  FIFO empty flag.
- fifo_rd_op  out  1  FIFO pop strobe, one per consumed word.
- out_data  out  ODW  current slice.
- out_valid  out  1  slice valid.
- out_ready  in  1  sink accepts slice.
- out_last  out  1  current slice is the last slice of its word.
- flush  in  1  discard the held word and the remaining slices.
- busy  out  1  a word is held.
- word_cnt  out  CNTW  number of words fully emitted, saturating.

Behaviour:
- Single clock. All registers are reset synchronously by reset=1.
- Reset values: state=IDLE, idx=0, hold_data=0, word_cnt=0. Resulting outputs: out_valid=0, out_last=0, out_data=0, busy=0, fifo_rd_op=0 (fifo_rd_op is gated by ~reset).
- States:
  - IDLE: no word held.
  - SHIFT: a word is held in hold_data and idx selects the current slice.
- Output decode:
  - out_valid = busy = (state==SHIFT).
  - out_data = hold_data[idx*ODW +: ODW].
  - out_last = out_valid & (idx==RATIO-1).
- xfer = out_valid & out_ready.
- load = ~reset & ~flush & ~fifo_empty & (state==IDLE | (xfer & out_last)).
- fifo_rd_op = load. It is combinational, the same cycle the word is captured.
- Transitions and actions, in priority order:
  - flush=1: state→IDLE, idx→0, no pop, word_cnt unchanged. A coincident xfer is still counted by the sink but not by word_cnt.
  - load: hold_data←fifo_dataout, idx←0, state→SHIFT.
  - xfer & ~out_last: idx←idx+1.
  - xfer & out_last & ~load: state→IDLE.
- word_cnt increments on xfer & out_last & ~flush and saturates at 2^CNTW-1.
- Latency: the first slice is valid one cycle after the cycle in which fifo_empty=0 and the block is IDLE.
- Throughput: with out_ready held high and the FIFO non-empty, slices flow back-to-back. The last slice of word N is followed in the next cycle by slice 0 of word N+1, with no bubble.
- out_ready=0 stalls: out_data, idx and hold_data are held stable. out_valid must never drop without a transfer, except on flush or reset.
- FIFO empty at the last-slice transfer: state→IDLE, out_valid=0 next cycle.
- Reset mid-word: the held word is lost. Pointer resynchronisation is the FIFO's job (its own reset).

Decomposition:
- Shared package/include sc_fifo_pkg. It holds:
  - the state encodings IDLE=1'b0 and SHIFT=1'b1;
  - a clog2 constant function;
  - the RATIO/IDW legality check macro.
- No sub-module. The FIFO is instantiated beside this block at the parent level, not inside it.

Test Plan:
- Single word: IDW=32, RATIO=4, FIFO holds 0xDDCCBBAA, out_ready=1 → fifo_rd_op pulses once. out_data is 0xAA, 0xBB, 0xCC, 0xDD on four consecutive cycles, out_last on the 4th. word_cnt=1, then IDLE.
- Back-to-back: FIFO holds 0x03020100, 0x07060504, out_ready=1 → 8 consecutive valid slices 0x00..0x07 with no bubble. The second fifo_rd_op coincides with the 0x03 transfer. word_cnt=2.
- Backpressure: out_ready toggles 1,0,0,1,… during the word 0x44332211 → slice value held while stalled, order preserved, exactly 4 transfers, one pop.
- Empty guard: fifo_empty=1 for 20 cycles, out_ready=1 → fifo_rd_op never asserted, out_valid=0, word_cnt=0.
- Flush: flush=1 after slice 0x11 of 0x44332211, FIFO still holding 0x88776655 → next cycle IDLE with no pop in the flush cycle. The following cycle pops 0x88776655 and emits 0x55 first. word_cnt counts only 0x88776655.
- Reset mid-word: assert reset during slice 2 → next cycle out_valid=0, out_data=0, word_cnt=0, fifo_rd_op=0 for the whole reset duration.
